// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states, address width helper.
// No logic of its own.
// Imported by the align sub-module and the responder top.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    function automatic int addr_width(input int depth_words);
        return $clog2(depth_words);
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Lane steering for RV32 byte/half/word accesses: byte enables, replicated store data, extended load data.
// Purely combinational, zero latency.
// No handshake; the caller decides when the outputs are used.
module load_store_align
    import mem_pkg::*;
(
    input  logic        write,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        bad
);

    logic [31:0] rshift;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rshift = rword >> {addr_lo, 3'b000};
    assign rbyte  = rshift[7:0];
    assign rhalf  = addr_lo[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        byte_en    = 4'b0000;
        wdata_lane = wdata;
        rdata_ext  = 32'h0;
        bad        = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                byte_en    = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = funct3[2] ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
            end
            F3_H, F3_HU: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = funct3[2] ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
                bad        = addr_lo[0];
            end
            F3_W: begin
                byte_en   = 4'b1111;
                rdata_ext = rword;
                bad       = (addr_lo != 2'b00);
            end
            default: bad = 1'b1;
        endcase
        // Stores have no unsigned variants: any funct3 with bit 2 set is illegal.
        if (write && funct3[2]) begin
            bad = 1'b1;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data RAM answering RV32 load/store requests with configurable wait states.
// Latency: rsp_valid rises LATENCY+2 cycles after accept; one request in flight at a time.
// Backpressure: holds the response while rsp_ready=0; req_ready only asserted in IDLE.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = addr_width(DEPTH_WORDS);
    localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [CW-1:0] LAT_INIT = CW'(LATENCY);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            lat_write;
    logic [2:0]      lat_funct3;
    logic [31:0]     lat_addr;
    logic [31:0]     lat_wdata;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            accept;
    logic [AW-1:0]   word_idx;
    logic            out_of_range;
    logic            align_bad;
    logic            acc_err;
    logic [3:0]      byte_en;
    logic [31:0]     wdata_lane;
    logic [31:0]     rdata_ext;
    logic [31:0]     rword;

    assign req_ready    = (state == IDLE) && !rst;
    assign rsp_valid    = (state == RESP);
    assign accept       = req_valid && req_ready;
    assign word_idx     = lat_addr[AW+1:2];
    assign out_of_range = |lat_addr[31:AW+2];
    assign acc_err      = align_bad || out_of_range;
    assign rword        = mem[word_idx];

    load_store_align u_align (
        .write      (lat_write),
        .funct3     (lat_funct3),
        .addr_lo    (lat_addr[1:0]),
        .wdata      (lat_wdata),
        .rword      (rword),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext),
        .bad        (align_bad)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (LATENCY == 0) ? ACCESS : WAIT;
            WAIT:    if (cnt <= CW'(1)) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            lat_write  <= 1'b0;
            lat_funct3 <= 3'b000;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            rsp_rdata  <= 32'h0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                lat_write  <= req_write;
                lat_funct3 <= req_funct3;
                lat_addr   <= req_addr;
                lat_wdata  <= req_wdata;
                cnt        <= LAT_INIT;
            end
            if (state == WAIT && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (state == ACCESS) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_err || lat_write) ? 32'h0 : rdata_ext;
            end
        end
    end

    // The array ignores rst so a store already in ACCESS still lands.
    always_ff @(posedge clk) begin
        if (state == ACCESS && lat_write && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
                end
            end
        end
    end

endmodule
